// File: rtl/spi_send_pkg.sv
// Shared definitions for the SPI-slave transmit path (also used by the receive path).
package spi_send_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } spi_send_state_e;

    localparam int unsigned SPI_BITS_PER_BYTE     = 8;
    localparam logic [7:0]  SPI_IDLE_BYTE_DEFAULT = 8'hFF;
    // FIFO entry is {tlast, data}
    localparam int unsigned SPI_SEND_ENTRY_W      = SPI_BITS_PER_BYTE + 1;

endpackage

// File: rtl/spi_send_fifo.sv
// Synchronous FIFO for the SPI transmit path. Pop and push on a full/empty
// FIFO are ignored; level/full/empty are derived from the registered level.
module spi_send_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q,  level_d;
    logic             do_push, do_pop;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and level update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer/level registers, flushed on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/spi_send.sv
// SPI-slave transmit path (mode 0, MSB first). Bytes arrive over AXI-Stream,
// are buffered, and are shifted out on MISO as the external master clocks.
// spi_clk/spi_cs are oversampled in the axi_aclk domain.
// Optional: define SPI_SEND_UNDERRUN_CNT_EN to add underrun_cnt/underrun_clr.
module spi_send
    import spi_send_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter logic [7:0]  IDLE_BYTE   = SPI_IDLE_BYTE_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          axi_aclk,
    input  logic                          axi_areset,
    input  logic [7:0]                    s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic                          spi_clk,
    input  logic                          spi_cs,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun
`ifdef SPI_SEND_UNDERRUN_CNT_EN
    ,
    input  logic                          underrun_clr,
    output logic [15:0]                   underrun_cnt
`endif
);

    localparam logic [3:0] BYTE_BITS = 4'(SPI_BITS_PER_BYTE);

    // Synchronisers and edge detection
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic sclk_d1_q, sclk_d1_d;
    logic cs_d1_q,   cs_d1_d;
    logic sclk_s, cs_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    // AXI-Stream side
    logic rdy_q, rdy_d;
    logic fifo_push, fifo_pop;
    logic [SPI_SEND_ENTRY_W-1:0] fifo_dout;
    logic fifo_full, fifo_empty;

    // Transmit FSM
    spi_send_state_e state_q, state_d;
    logic [7:0] shift_q,    shift_d;
    logic [3:0] bit_cnt_q,  bit_cnt_d;
    logic       last_q,     last_d;
    logic       oe_q,       oe_d;
    logic       miso_q,     miso_d;
    logic       underrun_q, underrun_d;
    logic       load_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s &  sclk_d1_q;
    assign cs_rise   =  cs_s   & ~cs_d1_q;
    assign cs_fall   = ~cs_s   &  cs_d1_q;

    assign s_axis_tready = rdy_q & ~fifo_full;
    assign fifo_push     = s_axis_tvalid & s_axis_tready;

    assign spi_miso    = miso_q;
    assign spi_miso_oe = oe_q;
    assign underrun    = underrun_q;

    spi_send_fifo #(
        .WIDTH (SPI_SEND_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (axi_aclk),
        .rst   (axi_areset),
        .push  (fifo_push),
        .din   ({s_axis_tlast, s_axis_tdata}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Synchroniser shift and edge-detect next values
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   spi_cs};
        sclk_d1_d   = sclk_s;
        cs_d1_d     = cs_s;
        rdy_d       = 1'b1;
    end

    // Synchroniser, edge-detect and ready-enable registers
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_d1_q   <= 1'b0;
            cs_d1_q     <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sclk_d1_q   <= sclk_d1_d;
            cs_d1_q     <= cs_d1_d;
            rdy_q       <= rdy_d;
        end
    end

    // FSM next state; LOAD and a mid-frame byte boundary share the reload path
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        fifo_pop   = 1'b0;
        load_byte  = 1'b0;

        if (cs_fall) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_rise) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_byte = 1'b1;
                    state_d   = ST_SHIFT;
                end
                ST_SHIFT, ST_DRAIN: begin
                    if (sclk_rise && (bit_cnt_q < BYTE_BITS)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                    if (sclk_fall) begin
                        if (bit_cnt_q < BYTE_BITS) begin
                            shift_d = {shift_q[6:0], 1'b0};
                        end else if ((state_q == ST_DRAIN) || last_q) begin
                            state_d   = ST_DRAIN;
                            shift_d   = IDLE_BYTE;
                            bit_cnt_d = '0;
                        end else begin
                            load_byte = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (load_byte) begin
            bit_cnt_d = '0;
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shift_d  = fifo_dout[7:0];
                last_d   = fifo_dout[8];
            end else begin
                shift_d    = IDLE_BYTE;
                last_d     = 1'b0;
                underrun_d = 1'b1;
            end
        end

        oe_d   = (state_d == ST_SHIFT) || (state_d == ST_DRAIN);
        miso_d = oe_d ? shift_d[7] : 1'b0;
    end

    // FSM and registered outputs
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            oe_q       <= 1'b0;
            miso_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            oe_q       <= oe_d;
            miso_q     <= miso_d;
            underrun_q <= underrun_d;
        end
    end

`ifdef SPI_SEND_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    assign underrun_cnt = ucnt_q;

    // Saturating underrun counter; clear wins over increment
    always_comb begin
        ucnt_d = ucnt_q;
        if (underrun_clr) begin
            ucnt_d = '0;
        end else if (underrun_q && (ucnt_q != '1)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    // Underrun counter register
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            ucnt_q <= '0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_send.sv
// Self-checking bench for spi_send: vector table, hand-written corner
// sequences and randomized frames against a queue-based reference model.
module tb_spi_send;

    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  IDLE  = 8'hFF;
    localparam int unsigned HALF  = 8;   // axi clocks per spi_clk half-period

    logic       axi_aclk = 1'b0;
    logic       axi_areset;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic       spi_clk;
    logic       spi_cs;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [4:0] fifo_level;
    logic       underrun;
`ifdef SPI_SEND_UNDERRUN_CNT_EN
    logic        underrun_clr;
    logic [15:0] underrun_cnt;
`endif

    spi_send #(
        .FIFO_DEPTH  (DEPTH),
        .IDLE_BYTE   (IDLE),
        .SYNC_STAGES (2)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_areset    (axi_areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .spi_clk       (spi_clk),
        .spi_cs        (spi_cs),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .fifo_level    (fifo_level),
        .underrun      (underrun)
`ifdef SPI_SEND_UNDERRUN_CNT_EN
        ,
        .underrun_clr  (underrun_clr),
        .underrun_cnt  (underrun_cnt)
`endif
    );

    always #5 axi_aclk = ~axi_aclk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned under_seen = 0;

    logic [8:0] mq[$];       // model FIFO contents {tlast, data}
    logic [7:0] exp_q[$];    // model bytes expected on MISO
    logic [7:0] rx_bytes[$]; // bytes captured by the bench master

    typedef struct packed {
        logic [2:0]  n_push;
        logic [31:0] data;     // pushed byte i at [8*i +: 8]
        logic [3:0]  last;     // tlast for pushed byte i
        logic [2:0]  n_rx;
        logic [31:0] exp;      // received byte i at [8*i +: 8]
        logic [2:0]  exp_under;
    } vec_t;

    vec_t vecs[5];

    // Count underrun pulses seen on the pin
    always @(negedge axi_aclk) begin
        if (underrun === 1'b1) under_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge axi_aclk);
    endtask

    task automatic push_byte(input logic [7:0] d, input logic l);
        int unsigned t = 0;
        while (s_axis_tready !== 1'b1 && t < 200) begin
            @(negedge axi_aclk);
            t++;
        end
        if (s_axis_tready !== 1'b1) begin
            check("push_ready_timeout", {31'd0, s_axis_tready}, 32'd1);
        end else begin
            s_axis_tdata  = d;
            s_axis_tlast  = l;
            s_axis_tvalid = 1'b1;
            @(negedge axi_aclk);
            s_axis_tvalid = 1'b0;
            mq.push_back({l, d});
        end
    endtask

    // Mode-0 master: sample MISO just before each rising edge; the final
    // falling edge coincides with chip-select release.
    task automatic spi_frame(input int unsigned nbits);
        logic [7:0]  sh;
        int unsigned oe_bad;
        sh     = '0;
        oe_bad = 0;
        rx_bytes.delete();
        spi_cs = 1'b1;
        for (int unsigned b = 0; b < nbits; b++) begin
            wait_clks(HALF);
            sh = {sh[6:0], spi_miso};
            if (spi_miso_oe !== 1'b1) oe_bad++;
            spi_clk = 1'b1;
            wait_clks(HALF);
            if (b % 8 == 7) begin
                rx_bytes.push_back(sh);
                sh = '0;
            end
            if (b == nbits - 1) spi_cs = 1'b0;
            spi_clk = 1'b0;
        end
        if (nbits % 8 != 0) rx_bytes.push_back(sh);
        wait_clks(HALF);
        check("oe_during_frame", oe_bad, 0);
        check("oe_after_frame", {31'd0, spi_miso_oe}, 0);
        check("miso_after_frame", {31'd0, spi_miso}, 0);
    endtask

    // Reference: each byte slot of a frame takes the next buffered byte,
    // IDLE when the buffer is empty (an underrun) or once a tlast byte went out.
    task automatic model_frame(input int unsigned nbytes, output int unsigned under);
        logic       drain;
        logic [8:0] e;
        drain = 1'b0;
        under = 0;
        exp_q.delete();
        for (int unsigned k = 0; k < nbytes; k++) begin
            if (drain) begin
                exp_q.push_back(IDLE);
            end else if (mq.size() == 0) begin
                exp_q.push_back(IDLE);
                under++;
            end else begin
                e = mq.pop_front();
                exp_q.push_back(e[7:0]);
                drain = e[8];
            end
        end
    endtask

    task automatic run_frame_check(input string tag, input int unsigned nbytes);
        int unsigned u_exp;
        int unsigned u0;
        model_frame(nbytes, u_exp);
        u0 = under_seen;
        spi_frame(nbytes * 8);
        for (int unsigned i = 0; i < nbytes; i++) begin
            check($sformatf("%s_rx%0d", tag, i), {24'd0, rx_bytes[i]}, {24'd0, exp_q[i]});
        end
        check({tag, "_underruns"}, under_seen - u0, u_exp);
        check({tag, "_level"}, {27'd0, fifo_level}, mq.size());
    endtask

    initial begin
        int unsigned u0;
        int unsigned np;
        int unsigned nb;

        axi_areset    = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        spi_clk       = 1'b0;
        spi_cs        = 1'b0;
`ifdef SPI_SEND_UNDERRUN_CNT_EN
        underrun_clr  = 1'b0;
`endif

        vecs[0] = '{n_push: 3'd1, data: 32'h0000_00A5, last: 4'b0001,
                    n_rx: 3'd2, exp: 32'h0000_FFA5, exp_under: 3'd0};
        vecs[1] = '{n_push: 3'd0, data: 32'h0000_0000, last: 4'b0000,
                    n_rx: 3'd1, exp: 32'h0000_00FF, exp_under: 3'd1};
        vecs[2] = '{n_push: 3'd3, data: 32'h0081_C33C, last: 4'b0100,
                    n_rx: 3'd4, exp: 32'hFF81_C33C, exp_under: 3'd0};
        vecs[3] = '{n_push: 3'd1, data: 32'h0000_0012, last: 4'b0000,
                    n_rx: 3'd2, exp: 32'h0000_FF12, exp_under: 3'd1};
        vecs[4] = '{n_push: 3'd2, data: 32'h0000_E75A, last: 4'b0010,
                    n_rx: 3'd3, exp: 32'h00FF_E75A, exp_under: 3'd0};

        // Reset state
        wait_clks(3);
        check("rst_tready", {31'd0, s_axis_tready}, 0);
        check("rst_miso", {31'd0, spi_miso}, 0);
        check("rst_oe", {31'd0, spi_miso_oe}, 0);
        check("rst_level", {27'd0, fifo_level}, 0);
        check("rst_underrun", {31'd0, underrun}, 0);
        axi_areset = 1'b0;
        wait_clks(1);
        check("tready_after_rst", {31'd0, s_axis_tready}, 1);

        // Vector table
        for (int unsigned v = 0; v < 5; v++) begin
            for (int unsigned i = 0; i < vecs[v].n_push; i++) begin
                push_byte(vecs[v].data[8*i +: 8], vecs[v].last[i]);
            end
            wait_clks(1);
            check($sformatf("vec%0d_level_pre", v), {27'd0, fifo_level}, {29'd0, vecs[v].n_push});
            u0 = under_seen;
            spi_frame(8 * vecs[v].n_rx);
            for (int unsigned i = 0; i < vecs[v].n_rx; i++) begin
                check($sformatf("vec%0d_rx%0d", v, i), {24'd0, rx_bytes[i]},
                      {24'd0, vecs[v].exp[8*i +: 8]});
            end
            check($sformatf("vec%0d_underruns", v), under_seen - u0, {29'd0, vecs[v].exp_under});
            check($sformatf("vec%0d_level_post", v), {27'd0, fifo_level}, 0);
            mq.delete();
        end

        // Fill to full with the bus idle; a 17th byte is refused
        for (int unsigned i = 0; i < DEPTH; i++) begin
            push_byte(8'($urandom), (i == DEPTH - 1));
        end
        wait_clks(1);
        check("full_level", {27'd0, fifo_level}, DEPTH);
        check("full_tready", {31'd0, s_axis_tready}, 0);
        s_axis_tdata  = 8'h99;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        wait_clks(4);
        s_axis_tvalid = 1'b0;
        check("full_level_hold", {27'd0, fifo_level}, DEPTH);
        run_frame_check("full_pop1", 1);
        check("tready_after_pop", {31'd0, s_axis_tready}, 1);
        run_frame_check("full_rest", DEPTH);

        // Frame aborted after 3 bits of F0; next frame starts on the following byte
        push_byte(8'hF0, 1'b0);
        push_byte(8'h5A, 1'b1);
        spi_frame(3);
        check("partial_bits", {24'd0, rx_bytes[0]}, 32'h07);
        void'(mq.pop_front());
        check("partial_level", {27'd0, fifo_level}, 1);
        run_frame_check("after_partial", 2);

        // Randomized frames against the reference model
        for (int unsigned it = 0; it < 20; it++) begin
            np = $urandom_range(0, 4);
            if (np > DEPTH - mq.size()) np = DEPTH - mq.size();
            for (int unsigned i = 0; i < np; i++) begin
                push_byte(8'($urandom), 1'($urandom_range(0, 3) == 0));
            end
            nb = $urandom_range(1, 5);
            run_frame_check($sformatf("rnd%0d", it), nb);
        end

        // Asynchronous reset in the middle of a byte
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b1);
        spi_cs = 1'b1;
        wait_clks(HALF);
        spi_clk = 1'b1;
        wait_clks(4);
        #2 axi_areset = 1'b1;
        #1;
        check("midrst_oe", {31'd0, spi_miso_oe}, 0);
        check("midrst_miso", {31'd0, spi_miso}, 0);
        check("midrst_level", {27'd0, fifo_level}, 0);
        check("midrst_tready", {31'd0, s_axis_tready}, 0);
        spi_clk = 1'b0;
        spi_cs  = 1'b0;
        mq.delete();
        wait_clks(3);
        axi_areset = 1'b0;
        wait_clks(1);
        check("midrst_tready_release", {31'd0, s_axis_tready}, 1);
        wait_clks(4);

`ifdef SPI_SEND_UNDERRUN_CNT_EN
        check("ucnt_after_rst", {16'd0, underrun_cnt}, 0);
        for (int unsigned i = 0; i < 3; i++) begin
            run_frame_check($sformatf("ucnt_frame%0d", i), 1);
        end
        check("ucnt_three", {16'd0, underrun_cnt}, 3);
        underrun_clr = 1'b1;
        wait_clks(1);
        underrun_clr = 1'b0;
        wait_clks(1);
        check("ucnt_cleared", {16'd0, underrun_cnt}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_send.md
Name: spi_send

Overview:
- SPI-slave transmit path: accepts bytes from the CCU over AXI-Stream, buffers them and shifts them out on MISO when the external master clocks the bus.
- Counterpart of the SPI receive path; shares spi_clk/spi_cs with it.
- Runs entirely in the axi_aclk domain: spi_clk and spi_cs are oversampled through synchronisers. No second clock domain.

Parameters:
- FIFO_DEPTH, 16, byte-buffer depth; power of two, minimum 4.
- IDLE_BYTE, 8'hFF, byte shifted out on underrun and after a frame's tlast byte.
- SYNC_STAGES, 2, synchroniser flops on spi_clk and spi_cs; minimum 2.

Ports:
- axi_aclk  in  1  system clock. Must be at least 8x spi_clk.
- axi_areset  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  8  byte from CCU.
- s_axis_tvalid  in  1  CCU byte valid.
- s_axis_tready  out  1  block can accept a byte.
- s_axis_tlast  in  1  last byte of a response frame.
- spi_clk  in  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0).
- spi_cs  in  1  chip select, active-high.
- spi_miso  out  1  serial data to master, MSB first.
- spi_miso_oe  out  1  MISO output enable; high only while the frame is active.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently buffered.
- underrun  out  1  one-cycle pulse when IDLE_BYTE is substituted because the FIFO is empty.

Behaviour:
- Reset values: s_axis_tready=0 while axi_areset is high, 1 on the first clock after release (if not full). spi_miso=0, spi_miso_oe=0, fifo_level=0, underrun=0. State=IDLE. FIFO is flushed.
- Input side: push when s_axis_tvalid && s_axis_tready. s_axis_tready = !full. Each entry stores {tlast, data}, 9 bits.
- Synchronisation:
  - cs_s and sclk_s are the outputs of the SYNC_STAGES flops.
  - Rise and fall edges are detected with one extra register stage.
  - All SPI events therefore lag the pins by SYNC_STAGES+1 cycles.
- States: IDLE, LOAD, SHIFT, DRAIN.
- IDLE:
  - spi_miso_oe=0.
  - cs_s rising -> LOAD.
- LOAD (1 cycle):
  - If the FIFO is non-empty: pop into shift_reg[7:0] and latch the entry's tlast into last_q.
  - If the FIFO is empty: shift_reg=IDLE_BYTE, last_q=0, underrun pulses.
  - bit_cnt=0, spi_miso_oe=1.
  - Next state is SHIFT.
- SHIFT:
  - spi_miso=shift_reg[7] continuously.
  - sclk rising: bit_cnt += 1 (4-bit counter, saturates at 8).
  - sclk falling with bit_cnt<8: shift_reg shifts left by 1 (LSB filled with 0).
  - sclk falling with bit_cnt==8: byte complete. If last_q=1, go to DRAIN. Otherwise reload exactly as in LOAD, in the same cycle, with bit_cnt=0.
- DRAIN:
  - shift_reg is reloaded with IDLE_BYTE at every byte boundary.
  - The FIFO is never popped and underrun is never pulsed.
  - A new frame starts only after spi_cs deasserts and reasserts.
- cs_s falling in any state:
  - Go to IDLE; spi_miso_oe=0, spi_miso=0, bit_cnt=0.
  - A partially shifted byte is discarded; it was already popped and is not re-sent.
- Simultaneous push and pop: both take effect, fifo_level unchanged. A push into a full FIFO cannot happen (tready=0).
- A pop on the same cycle as a push into an empty FIFO is not allowed. LOAD checks empty registered from the previous cycle, so an empty FIFO yields IDLE_BYTE.
- Reset mid-frame: all state is cleared immediately (asynchronous). MISO is released, buffered bytes are lost.

Optional Feature:
- Macro: SPI_SEND_UNDERRUN_CNT_EN.
- When defined:
  - Adds output underrun_cnt [15:0], which increments on every underrun pulse and saturates at 16'hFFFF.
  - Adds input underrun_clr; when high it clears the counter, taking priority over a simultaneous increment.
  - Reset value of the counter is 0.
- When undefined: neither port exists; underrun is still present.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, LOAD, SHIFT, DRAIN as 2-bit localparams);
  - SPI_BITS_PER_BYTE = 8;
  - the default IDLE_BYTE constant, shared with the receive path.
- One sub-module, spi_send_fifo: synchronous FIFO, width 9, depth FIFO_DEPTH. It provides push, pop, dout, full, empty and level, with an asynchronous active-high reset.

Test Plan:
- Push 8'hA5 (tlast=1). Assert cs, run 16 mode-0 clocks -> master samples 1010_0101 then 1111_1111, underrun never pulses, fifo_level 1->0.
- Empty FIFO, assert cs, 8 clocks -> MISO shows 8'hFF, underrun pulses once, spi_miso_oe=1 only while cs is high.
- Push 8'h3C, 8'hC3, 8'h81 (tlast on the last byte) back-to-back, 24 clocks -> 3C, C3, 81 in order, no gaps, then IDLE_BYTE.
- Push FIFO_DEPTH+1 bytes with the bus idle -> s_axis_tready drops after 16 accepted, fifo_level=16. Popping one byte restores tready=1.
- Deassert cs after 3 bits of 8'hF0, then reassert -> the next frame starts with the following FIFO byte, and bit_cnt restarts at 0.
- Assert axi_areset mid-byte -> spi_miso_oe=0 and fifo_level=0 immediately. With SPI_SEND_UNDERRUN_CNT_EN, 3 underruns then underrun_clr -> underrun_cnt reads 3, then 0.
